// File: rtl/bus_port_fifo_pkg.sv
// Shared constants and helpers for the bus port endpoint.
package bus_port_pkg;

    localparam int STAT_W       = 16;
    localparam int DEST_MSB_OFS = 8;
    localparam logic [7:0] BCAST_ID = 8'hFF;

    // Pointer width including the wrap bit
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bus_port_fifo_if.sv
// Host-side and arbiter-side handshake bundle for one bus port endpoint.
interface bus_port_fifo_if #(
    parameter int PCKG_SZ = 16,
    parameter int DEPTH   = 8
);
    import bus_port_pkg::*;
    localparam int CW = ptr_w(DEPTH);

    logic               tx_valid;
    logic [PCKG_SZ-1:0] tx_data;
    logic               tx_ready;
    logic               pndng;
    logic [PCKG_SZ-1:0] D_pop;
    logic               pop;
    logic               push;
    logic [PCKG_SZ-1:0] D_push;
    logic               rx_valid;
    logic [PCKG_SZ-1:0] rx_data;
    logic               rx_ready;
    logic [CW-1:0]      tx_count;
    logic [CW-1:0]      rx_count;
    logic               tx_full;
    logic               rx_full;
    logic [STAT_W-1:0]  rx_drop_cnt;
    logic [STAT_W-1:0]  pop_uflow_cnt;

    modport slave (
        input  tx_valid, tx_data, pop, push, D_push, rx_ready,
        output tx_ready, pndng, D_pop, rx_valid, rx_data,
               tx_count, rx_count, tx_full, rx_full, rx_drop_cnt, pop_uflow_cnt
    );

    modport master (
        output tx_valid, tx_data, pop, push, D_push, rx_ready,
        input  tx_ready, pndng, D_pop, rx_valid, rx_data,
               tx_count, rx_count, tx_full, rx_full, rx_drop_cnt, pop_uflow_cnt
    );

endinterface

// File: rtl/bus_port_sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers; storage cleared on reset.
module bus_port_sync_fifo
    import bus_port_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [W-1:0]              wr_data,
    input  logic                      rd_en,
    output logic [W-1:0]              rd_data,
    output logic                      full,
    output logic                      empty,
    output logic [ptr_w(DEPTH)-1:0]   count
);
    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]             r_wr_ptr;
    logic [PW-1:0]             r_rd_ptr;
    logic [DEPTH-1:0][W-1:0]   r_mem;
    logic                      w_wr;
    logic                      w_rd;

    // Self-guarded so a stray enable can never corrupt the pointers
    assign w_rd = rd_en && !empty;
    assign w_wr = wr_en && (!full || w_rd);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_mem    <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
                r_wr_ptr                <= r_wr_ptr + PW'(1);
            end
            if (w_rd)
                r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign count   = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/bus_port_fifo.sv
// Bus port endpoint: TX FIFO toward the arbiter, RX FIFO toward the host.
// Optional error counters enabled by `define BUS_PORT_FIFO_STATS_EN.
module bus_port_fifo
    import bus_port_pkg::*;
#(
    parameter int PCKG_SZ = 16,
    parameter int DEPTH   = 8
) (
    input  logic           clk,
    input  logic           reset,
    bus_port_fifo_if.slave bus
);
    logic w_tx_wr, w_tx_rd, w_tx_full, w_tx_empty;
    logic w_rx_wr, w_rx_rd, w_rx_full, w_rx_empty;

    assign w_tx_wr = bus.tx_valid && !w_tx_full;
    assign w_tx_rd = bus.pop && !w_tx_empty;
    assign w_rx_rd = bus.rx_ready && !w_rx_empty;
    // No backpressure on the bus: a push into a full RX survives only if a read frees a slot
    assign w_rx_wr = bus.push && (!w_rx_full || w_rx_rd);

    bus_port_sync_fifo #(.W(PCKG_SZ), .DEPTH(DEPTH)) u_tx (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_tx_wr),
        .wr_data (bus.tx_data),
        .rd_en   (w_tx_rd),
        .rd_data (bus.D_pop),
        .full    (w_tx_full),
        .empty   (w_tx_empty),
        .count   (bus.tx_count)
    );

    bus_port_sync_fifo #(.W(PCKG_SZ), .DEPTH(DEPTH)) u_rx (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_rx_wr),
        .wr_data (bus.D_push),
        .rd_en   (w_rx_rd),
        .rd_data (bus.rx_data),
        .full    (w_rx_full),
        .empty   (w_rx_empty),
        .count   (bus.rx_count)
    );

    assign bus.tx_ready = !w_tx_full;
    assign bus.tx_full  = w_tx_full;
    assign bus.pndng    = !w_tx_empty;
    assign bus.rx_valid = !w_rx_empty;
    assign bus.rx_full  = w_rx_full;

`ifdef BUS_PORT_FIFO_STATS_EN
    logic [STAT_W-1:0] r_rx_drop_cnt;
    logic [STAT_W-1:0] r_pop_uflow_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_drop_cnt   <= '0;
            r_pop_uflow_cnt <= '0;
        end else begin
            if (bus.push && !w_rx_wr && (r_rx_drop_cnt != '1))
                r_rx_drop_cnt <= r_rx_drop_cnt + STAT_W'(1);
            if (bus.pop && w_tx_empty && (r_pop_uflow_cnt != '1))
                r_pop_uflow_cnt <= r_pop_uflow_cnt + STAT_W'(1);
        end
    end

    assign bus.rx_drop_cnt   = r_rx_drop_cnt;
    assign bus.pop_uflow_cnt = r_pop_uflow_cnt;
`else
    assign bus.rx_drop_cnt   = '0;
    assign bus.pop_uflow_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_port_fifo.sv
// Self-checking bench for bus_port_fifo: vector table plus queue scoreboard.
module tb_bus_port_fifo;
    import bus_port_pkg::*;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int CW = ptr_w(D);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_port_fifo_if #(.PCKG_SZ(W), .DEPTH(D)) bus ();
    bus_port_fifo #(.PCKG_SZ(W), .DEPTH(D)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;
    logic [W-1:0] tx_q[$];
    logic [W-1:0] rx_q[$];

    typedef struct {
        logic          tv;
        logic [W-1:0]  td;
        logic          p;
        logic          pu;
        logic [W-1:0]  dp;
        logic          rr;
        logic          e_pndng;
        logic [W-1:0]  e_dpop;
        logic [CW-1:0] e_txc;
        logic          e_rxv;
        logic [W-1:0]  e_rxd;
        logic [CW-1:0] e_rxc;
    } vec_t;

    vec_t vt[8];

`ifdef BUS_PORT_FIFO_STATS_EN
    localparam logic [15:0] EXP_DROP  = 16'd1;
    localparam logic [15:0] EXP_UFLOW = 16'd1;
`else
    localparam logic [15:0] EXP_DROP  = 16'd0;
    localparam logic [15:0] EXP_UFLOW = 16'd0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic tv, input logic [W-1:0] td, input logic p,
                         input logic pu, input logic [W-1:0] dp, input logic rr);
        bus.tx_valid = tv;
        bus.tx_data  = td;
        bus.pop      = p;
        bus.push     = pu;
        bus.D_push   = dp;
        bus.rx_ready = rr;
    endtask

    // One cycle against the scoreboard: outputs checked before the edge, model updated with it
    task automatic cyc(input logic tv, input logic [W-1:0] td, input logic p,
                       input logic pu, input logic [W-1:0] dp, input logic rr);
        bit txa, txr, rxr, rxw;
        logic [W-1:0] tmp;
        drive(tv, td, p, pu, dp, rr);
        check("tx_count", 32'(bus.tx_count), 32'(tx_q.size()));
        check("tx_ready", 32'(bus.tx_ready), 32'(tx_q.size() < D));
        check("pndng", 32'(bus.pndng), 32'(tx_q.size() > 0));
        if (tx_q.size() > 0) check("D_pop", 32'(bus.D_pop), 32'(tx_q[0]));
        check("rx_count", 32'(bus.rx_count), 32'(rx_q.size()));
        check("rx_valid", 32'(bus.rx_valid), 32'(rx_q.size() > 0));
        if (rx_q.size() > 0) check("rx_data", 32'(bus.rx_data), 32'(rx_q[0]));
        txr = p && (tx_q.size() > 0);
        txa = tv && (tx_q.size() < D);
        rxr = rr && (rx_q.size() > 0);
        rxw = pu && ((rx_q.size() < D) || rxr);
        if (txr) tmp = tx_q.pop_front();
        if (txa) tx_q.push_back(td);
        if (rxr) tmp = rx_q.pop_front();
        if (rxw) rx_q.push_back(dp);
        tick();
    endtask

    initial begin
        logic [W-1:0] hold;

        vt[0] = '{1'b1, 16'h0201, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0201, 4'd1, 1'b0, 16'h0, 4'd0};
        vt[1] = '{1'b1, 16'h0302, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0201, 4'd2, 1'b0, 16'h0, 4'd0};
        vt[2] = '{1'b1, 16'h0403, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0201, 4'd3, 1'b0, 16'h0, 4'd0};
        vt[3] = '{1'b0, 16'h0,    1'b0, 1'b1, 16'hFF11, 1'b0, 1'b1, 16'h0201, 4'd3, 1'b1, 16'hFF11, 4'd1};
        vt[4] = '{1'b0, 16'h0,    1'b1, 1'b1, 16'h0122, 1'b0, 1'b1, 16'h0302, 4'd2, 1'b1, 16'hFF11, 4'd2};
        vt[5] = '{1'b0, 16'h0,    1'b1, 1'b0, 16'h0,    1'b1, 1'b1, 16'h0403, 4'd1, 1'b1, 16'h0122, 4'd1};
        vt[6] = '{1'b0, 16'h0,    1'b1, 1'b0, 16'h0,    1'b1, 1'b0, 16'h0,    4'd0, 1'b0, 16'h0,    4'd0};
        vt[7] = '{1'b0, 16'h0,    1'b0, 1'b0, 16'h0,    1'b0, 1'b0, 16'h0,    4'd0, 1'b0, 16'h0,    4'd0};

        // Reset values
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_pndng", 32'(bus.pndng), 32'd0);
        check("rst_D_pop", 32'(bus.D_pop), 32'd0);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_rx_data", 32'(bus.rx_data), 32'd0);
        check("rst_tx_count", 32'(bus.tx_count), 32'd0);
        check("rst_rx_count", 32'(bus.rx_count), 32'd0);
        check("rst_tx_full", 32'(bus.tx_full), 32'd0);
        check("rst_rx_full", 32'(bus.rx_full), 32'd0);
        check("rst_drop", 32'(bus.rx_drop_cnt), 32'd0);
        check("rst_uflow", 32'(bus.pop_uflow_cnt), 32'd0);

        // Vector table: in-order TX with RX traffic alongside
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].tv, vt[i].td, vt[i].p, vt[i].pu, vt[i].dp, vt[i].rr);
            tick();
            check($sformatf("vec%0d_pndng", i), 32'(bus.pndng), 32'(vt[i].e_pndng));
            if (vt[i].e_pndng) check($sformatf("vec%0d_D_pop", i), 32'(bus.D_pop), 32'(vt[i].e_dpop));
            check($sformatf("vec%0d_tx_count", i), 32'(bus.tx_count), 32'(vt[i].e_txc));
            check($sformatf("vec%0d_rx_valid", i), 32'(bus.rx_valid), 32'(vt[i].e_rxv));
            if (vt[i].e_rxv) check($sformatf("vec%0d_rx_data", i), 32'(bus.rx_data), 32'(vt[i].e_rxd));
            check($sformatf("vec%0d_rx_count", i), 32'(bus.rx_count), 32'(vt[i].e_rxc));
        end

        // TX full: 9th offer refused, also refused alongside a pop, accepted after
        for (int i = 0; i < 8; i++) cyc(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0, '0, 1'b0);
        check("txfull_ready", 32'(bus.tx_ready), 32'd0);
        check("txfull_full", 32'(bus.tx_full), 32'd1);
        cyc(1'b1, 16'hA0FF, 1'b0, 1'b0, '0, 1'b0);
        check("txfull_count", 32'(bus.tx_count), 32'd8);
        cyc(1'b1, 16'hA0FF, 1'b1, 1'b0, '0, 1'b0);
        check("txfull_ready_after_pop", 32'(bus.tx_ready), 32'd1);
        check("txfull_count_after_pop", 32'(bus.tx_count), 32'd7);
        cyc(1'b1, 16'hA0FF, 1'b0, 1'b0, '0, 1'b0);
        check("txfull_9th_in", 32'(bus.tx_count), 32'd8);
        for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        check("txdrain_pndng", 32'(bus.pndng), 32'd0);

        // RX full: push dropped without a read, accepted with one
        for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b0, 1'b1, 16'hB000 + 16'(i), 1'b0);
        check("rxfull_full", 32'(bus.rx_full), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b1, 16'hFFAA, 1'b0);
        check("rxdrop_count", 32'(bus.rx_count), 32'd8);
        check("rxdrop_cnt", 32'(bus.rx_drop_cnt), 32'(EXP_DROP));
        cyc(1'b0, '0, 1'b0, 1'b1, 16'hFFAA, 1'b1);
        check("rxfull_rdwr_count", 32'(bus.rx_count), 32'd8);
        check("rxdrop_cnt_hold", 32'(bus.rx_drop_cnt), 32'(EXP_DROP));
        for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        check("rxdrain_valid", 32'(bus.rx_valid), 32'd0);

        // Pop on empty TX
        hold = bus.D_pop;
        cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        check("uflow_D_pop_stable", 32'(bus.D_pop), 32'(hold));
        check("uflow_tx_count", 32'(bus.tx_count), 32'd0);
        check("uflow_pndng", 32'(bus.pndng), 32'd0);
        check("uflow_cnt", 32'(bus.pop_uflow_cnt), 32'(EXP_UFLOW));
`ifdef BUS_PORT_FIFO_STATS_EN
        bus.pop = 1'b1;
        for (int i = 0; i < 69999; i++) tick();
        bus.pop = 1'b0;
        check("uflow_saturate", 32'(bus.pop_uflow_cnt), 32'h0000FFFF);
        check("uflow_sat_D_pop", 32'(bus.D_pop), 32'(hold));
`endif

        // Write and pop every cycle across pointer wrap
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 16'hC000 + 16'(i), tx_q.size() > 0, 1'b0, '0, 1'b0);
            check("interleave_le1", 32'(bus.tx_count <= 1), 32'd1);
        end
        cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        check("interleave_empty", 32'(bus.pndng), 32'd0);

        // Reset mid-operation with all handshakes active
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'hD000 + 16'(i), 1'b0, 1'b1, 16'hE000 + 16'(i), 1'b0);
        check("pre_rst_tx_count", 32'(bus.tx_count), 32'd5);
        check("pre_rst_rx_count", 32'(bus.rx_count), 32'd5);
        drive(1'b1, 16'hDEAD, 1'b1, 1'b1, 16'hBEEF, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        tx_q.delete();
        rx_q.delete();
        check("midrst_tx_count", 32'(bus.tx_count), 32'd0);
        check("midrst_rx_count", 32'(bus.rx_count), 32'd0);
        check("midrst_pndng", 32'(bus.pndng), 32'd0);
        check("midrst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("midrst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("midrst_drop", 32'(bus.rx_drop_cnt), 32'd0);
        check("midrst_uflow", 32'(bus.pop_uflow_cnt), 32'd0);
        cyc(1'b1, 16'hF00D, 1'b0, 1'b1, 16'h0F0F, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_port_fifo.md
# bus_port_fifo

Device-side endpoint for the bus generator/arbiter. Connects to one bus port (`pndng`/`pop`/`D_pop` toward the arbiter, `push`/`D_push` from it). The block buffers outbound packets from a local host in a TX FIFO and presents them to the bus as pending. It captures inbound bus pushes in an RX FIFO for the host. One instance per bus port replaces the behavioural FIFO models in the bench and in integrated systems.

## Interface
- `PCKG_SZ`, default 16: packet width in bits; the top 8 bits are the destination ID.
- `DEPTH`, default 8: entries per FIFO; must be a power of two, ≥2.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `tx_valid`  in  1: host offers a packet.
- `tx_data`  in  PCKG_SZ: host packet.
- `tx_ready`  out  1: equals `!tx_full`.
- `pndng`  out  1: TX FIFO not empty.
- `D_pop`  out  PCKG_SZ: TX FIFO head (show-ahead).
- `pop`  in  1: arbiter consumes the head.
- `push`  in  1: arbiter delivers a packet.
- `D_push`  in  PCKG_SZ: delivered packet.
- `rx_valid`  out  1: RX FIFO not empty.
- `rx_data`  out  PCKG_SZ: RX FIFO head (show-ahead).
- `rx_ready`  in  1: host consumes the RX head.
- `tx_count`, `rx_count`  out  $clog2(DEPTH)+1: occupancy.
- `tx_full`, `rx_full`  out  1: occupancy == DEPTH.
- `rx_drop_cnt`, `pop_uflow_cnt`  out  16: error counters (see Configuration).

## Operation
- TX write: occurs when `tx_valid && tx_ready`. Offers while full are ignored, and the host must hold them.
- TX read: occurs when `pop && pndng`. The head advances.
- `pop` while empty is ignored: no pointer movement and no X on `D_pop`, which keeps its last value.
- RX write: occurs when `push` and (`!rx_full` or an RX read happens in the same cycle). The bus has no backpressure, so a push to a full FIFO with no simultaneous read is dropped.
- RX read: occurs when `rx_valid && rx_ready`. `rx_ready` while empty is ignored.
- Simultaneous read and write on a non-empty, non-full FIFO: count unchanged, both pointers advance.
- Simultaneous TX write and `pop` at full: the write is refused, because `tx_ready` depends only on `tx_full`.
- Pointers are `$clog2(DEPTH)+1` bits with wrap bit. Full means the low bits are equal and the wrap bits differ. Empty means the pointers are equal.
- Reset values: all pointers and counts are 0. `pndng`, `rx_valid`, `tx_full`, `rx_full` and both error counters are 0. `tx_ready` is 1. `D_pop`/`rx_data` are 0, because storage is cleared on reset.
- Reset asserted mid-operation flushes both FIFOs on that edge. Any write or read sampled in the same cycle as `reset` is discarded.
- Packet contents are never inspected or modified. The destination ID is passed through.

## Timing
- TX write at edge N: `pndng` is 1 and `D_pop` holds the packet after edge N, i.e. visible in cycle N+1. Latency is 1 cycle.
- `pop` at edge N: the next head appears on `D_pop` after edge N. `pndng` falls after edge N if that was the last entry.
- `push` at edge N: `rx_valid`/`rx_data` are valid after edge N.
- `D_pop` and `rx_data` are driven from registered storage through a pointer-indexed mux. There is no combinational path from `pop`, `push`, `tx_valid` or `rx_ready` to any data output.
- `tx_ready` is a function of registered state only.

## Configuration
- Macro: `BUS_PORT_FIFO_STATS_EN`.
- Defined: `rx_drop_cnt` increments on every dropped push. `pop_uflow_cnt` increments on every `pop` while `!pndng`. Both saturate at 16'hFFFF and are cleared by `reset`.
- Undefined: both ports are tied to 0 and no counter logic is built. All other behaviour is identical.

## Structure
- Package `bus_port_pkg`:
  - `STAT_W` = 16.
  - `DEST_MSB_OFS` = 8 (width of the destination ID field).
  - `BCAST_ID` = 8'hFF.
  - Function `ptr_w(depth)` returning `$clog2(depth)+1`.
- Sub-module `bus_port_sync_fifo` (params `W`, `DEPTH`):
  - Ports: `wr_en`, `wr_data`, `rd_en`, `rd_data`, `full`, `empty`, `count`.
  - Instantiated twice. The top adds the handshake qualifiers, the RX full-with-read rule and the stats counters.

## Test plan
- Reset, then 3 TX writes (16'h0201, 16'h0302, 16'h0403), no pop: `pndng`=1, `D_pop`=16'h0201, `tx_count`=3. Three single-cycle pops return the packets in order, then `pndng`=0.
- Fill TX with 8 writes, offer a 9th with `pop` held low: `tx_ready`=0, the 9th is not stored. Pop one: `tx_ready`=1 next cycle, the 9th is accepted.
- Fill RX with 8 pushes, push 16'hFFAA without `rx_ready`: dropped, and `rx_drop_cnt`=1 with the macro. Repeat with `rx_ready`=1 in the same cycle: accepted, `rx_count` stays 8.
- `pop` pulsed on an empty TX: no state change, `D_pop` is stable. With the macro, `pop_uflow_cnt`=1, and it saturates at 16'hFFFF after 70000 pulses.
- Interleave TX writes and pops every cycle across 20 packets, exercising pointer wrap: output order equals input order and `tx_count` stays ≤1.
- Assert `reset` for one cycle with 5 entries in each FIFO and `push`/`pop` active: next cycle all counts are 0, `pndng`=`rx_valid`=0, counters are 0.
